// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier with BCD readout.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

  // Enough decimal digits for a 2n-bit magnitude.
  function automatic int digit_count(input int n);
    return ((2 * n) / 3) + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. The load cycle performs the first shift,
// so a W-bit value takes exactly W clock edges; done marks the final shift cycle.
module bin2bcd_seq
  import mul_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     bin,
  output logic [BCD_W*D-1:0] bcd,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]         bin_r;
  logic [BCD_W*D-1:0]   bcd_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;

  function automatic logic [BCD_W*D-1:0] dabble_adjust(input logic [BCD_W*D-1:0] v);
    logic [BCD_W*D-1:0] r;
    r = v;
    for (int d = 0; d < D; d++) begin
      if (v[d*BCD_W +: BCD_W] >= ADD3_TH) begin
        r[d*BCD_W +: BCD_W] = v[d*BCD_W +: BCD_W] + 4'd3;
      end else begin
        r[d*BCD_W +: BCD_W] = v[d*BCD_W +: BCD_W];
      end
    end
    return r;
  endfunction

  // Shift/adjust core; digits are empty at load so no adjust is needed then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_r  <= '0;
      bcd_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (load) begin
      bin_r  <= bin << 1;
      bcd_r  <= {{(BCD_W*D-1){1'b0}}, bin[W-1]};
      cnt_r  <= CNT_LOAD;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      bin_r  <= bin_r << 1;
      bcd_r  <= (dabble_adjust(bcd_r) << 1) | {{(BCD_W*D-1){1'b0}}, bin_r[W-1]};
      cnt_r  <= cnt_r - CNT_ONE;
      busy_r <= (cnt_r != CNT_ONE);
    end else begin
      bin_r  <= bin_r;
      bcd_r  <= bcd_r;
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

  assign bcd  = bcd_r;
  assign busy = busy_r;
  assign done = busy_r && (cnt_r == CNT_ONE);

endmodule

// File: rtl/mul_seq_bcd.sv
// Sequential signed (radix-2 Booth) / unsigned (shift-add) multiplier whose
// product magnitude is converted to BCD before a one-cycle finish pulse.
module mul_seq_bcd
  import mul_pkg::*;
#(
  parameter  int N      = 8,
  localparam int DIGITS = digit_count(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [N-1:0]            a_in,
  input  logic [N-1:0]            b_in,
  output logic [2*N-1:0]          out,
  output logic [DIGITS*BCD_W-1:0] bcd,
  output logic                    neg,
  output logic                    busy,
  output logic                    finish
);

  localparam int            CW       = $clog2(2 * N + 1);
  localparam logic [CW-1:0] CNT_MUL  = CW'(N);
  localparam logic [CW-1:0] CNT_CONV = CW'(2 * N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t                    state_r, next_s;
  logic [CW-1:0]             cnt_r;
  logic [N-1:0]              a_r, hi_r, lo_r;
  logic                      qm1_r, sgn_r;
  logic [2*N-1:0]            out_r;
  logic [DIGITS*BCD_W-1:0]   bcd_r;
  logic                      neg_r, busy_r, finish_r;

  logic [N:0]                ext_hi_s, ext_a_s, sum_s;
  logic [2*N-1:0]            prod_s, mag_s;
  logic                      neg_s;
  logic                      conv_load_s, conv_busy_s, conv_done_s;
  logic [DIGITS*BCD_W-1:0]   conv_bcd_s;

  // One Booth / shift-add iteration, computed one bit wider so the carry or sign survives the shift.
  always_comb begin
    ext_hi_s = sgn_r ? {hi_r[N-1], hi_r} : {1'b0, hi_r};
    ext_a_s  = sgn_r ? {a_r[N-1], a_r}   : {1'b0, a_r};
    sum_s    = ext_hi_s;
    if (sgn_r) begin
      case ({lo_r[0], qm1_r})
        2'b01:   sum_s = ext_hi_s + ext_a_s;
        2'b10:   sum_s = ext_hi_s - ext_a_s;
        default: sum_s = ext_hi_s;
      endcase
    end else if (lo_r[0]) begin
      sum_s = ext_hi_s + ext_a_s;
    end else begin
      sum_s = ext_hi_s;
    end
  end

  assign prod_s      = {hi_r, lo_r};
  assign neg_s       = sgn_r & hi_r[N-1];
  assign mag_s       = neg_s ? (~prod_s + {{(2*N-1){1'b0}}, 1'b1}) : prod_s;
  assign conv_load_s = (state_r == ST_CONV) && (cnt_r == CNT_CONV) && !conv_busy_s;

  bin2bcd_seq #(
    .W (2 * N),
    .D (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .load  (conv_load_s),
    .bin   (mag_s),
    .bcd   (conv_bcd_s),
    .busy  (conv_busy_s),
    .done  (conv_done_s)
  );

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: next_s = start ? ST_MUL : ST_IDLE;
      ST_MUL:  next_s = (cnt_r == CNT_ONE) ? ST_CONV : ST_MUL;
      ST_CONV: next_s = conv_done_s ? ST_DONE : ST_CONV;
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      a_r      <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      qm1_r    <= 1'b0;
      sgn_r    <= 1'b0;
      out_r    <= '0;
      bcd_r    <= '0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      state_r  <= next_s;
      busy_r   <= (state_r != ST_IDLE) || (next_s != ST_IDLE);
      finish_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a_in;
            lo_r  <= b_in;
            sgn_r <= signed_mode;
            hi_r  <= '0;
            qm1_r <= 1'b0;
            cnt_r <= CNT_MUL;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_MUL: begin
          hi_r  <= sum_s[N:1];
          lo_r  <= {sum_s[0], lo_r[N-1:1]};
          qm1_r <= lo_r[0];
          cnt_r <= (cnt_r == CNT_ONE) ? CNT_CONV : (cnt_r - CNT_ONE);
        end
        ST_CONV: begin
          cnt_r <= (cnt_r != '0) ? (cnt_r - CNT_ONE) : cnt_r;
        end
        ST_DONE: begin
          out_r <= prod_s;
          bcd_r <= conv_bcd_s;
          neg_r <= neg_s;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign out    = out_r;
  assign bcd    = bcd_r;
  assign neg    = neg_r;
  assign busy   = busy_r;
  assign finish = finish_r;

endmodule

// File: tb/tb_mul_seq_bcd.sv
// Self-checking bench for mul_seq_bcd at N=5: table vectors, random ops against
// an arithmetic model, back-to-back launches, mid-run reset and ignored start.
module tb_mul_seq_bcd;

  localparam int N   = 5;
  localparam int DIG = ((2 * N) / 3) + 1;
  localparam int BW  = DIG * 4;
  localparam int LAT = 3 * N + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            signed_mode;
  logic [N-1:0]    a_in, b_in;
  logic [2*N-1:0]  out;
  logic [BW-1:0]   bcd;
  logic            neg, busy, finish;

  int checks   = 0;
  int failures = 0;

  mul_seq_bcd #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a_in        (a_in),
    .b_in        (b_in),
    .out         (out),
    .bcd         (bcd),
    .neg         (neg),
    .busy        (busy),
    .finish      (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           s;
    logic [2*N-1:0] eo;
    logic [BW-1:0]  eb;
    logic           en;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: integer product of the interpreted operands, decimal digits by division.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                output logic [2*N-1:0] eo, output logic [BW-1:0] eb,
                                output logic en);
    int pa, pb, p, m;
    pa = int'(a);
    pb = int'(b);
    if (s && a[N-1]) pa = pa - (1 << N);
    if (s && b[N-1]) pb = pb - (1 << N);
    p  = pa * pb;
    en = (p < 0);
    m  = en ? -p : p;
    eo = p[2*N-1:0];
    eb = '0;
    for (int d = 0; d < DIG; d++) begin
      eb[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  // Caller must be #1 after an edge with the DUT idle.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [2*N-1:0] eo, input logic [BW-1:0] eb, input logic en,
                       input string tag);
    int cyc;
    a_in = a; b_in = b; signed_mode = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = N'($urandom); b_in = N'($urandom); signed_mode = ~s;
    chk({tag, "_busy_rise"}, busy, 1);
    cyc = 0;
    while (finish !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, LAT);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_bcd"}, bcd, eb);
    chk({tag, "_neg"}, neg, en);
    @(posedge clk); #1;
    chk({tag, "_finish_fall"}, finish, 0);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    vec_t           tbl[7];
    logic [N-1:0]   ra, rb, ca, cb, na, nb;
    logic           rs, cs, ns, en;
    logic [2*N-1:0] eo, hold_out;
    logic [BW-1:0]  eb;
    int             stray, fin_cnt;

    tbl[0] = '{a: 5'd26, b: 5'd30, s: 1'b0, eo: 10'd780,  eb: 16'h0780, en: 1'b0};
    tbl[1] = '{a: 5'd13, b: 5'd13, s: 1'b0, eo: 10'd169,  eb: 16'h0169, en: 1'b0};
    tbl[2] = '{a: 5'd31, b: 5'd31, s: 1'b0, eo: 10'd961,  eb: 16'h0961, en: 1'b0};
    tbl[3] = '{a: 5'h1D, b: 5'd7,  s: 1'b1, eo: 10'h3EB,  eb: 16'h0021, en: 1'b1};
    tbl[4] = '{a: 5'h10, b: 5'h10, s: 1'b1, eo: 10'd256,  eb: 16'h0256, en: 1'b0};
    tbl[5] = '{a: 5'h10, b: 5'd15, s: 1'b1, eo: 10'h310,  eb: 16'h0240, en: 1'b1};
    tbl[6] = '{a: 5'd0,  b: 5'd17, s: 1'b0, eo: 10'd0,    eb: 16'h0000, en: 1'b0};

    reset = 1'b0; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_neg", neg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].eo, tbl[i].eb, tbl[i].en, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = N'($urandom); rb = N'($urandom); rs = 1'($urandom);
      model(ra, rb, rs, eo, eb, en);
      do_op(ra, rb, rs, eo, eb, en, $sformatf("rnd%0d", i));
    end

    // Start held high: three back-to-back launches with operands disturbed mid-run.
    ca = N'($urandom); cb = N'($urandom); cs = 1'b1;
    a_in = ca; b_in = cb; signed_mode = cs; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      model(ca, cb, cs, eo, eb, en);
      na = N'($urandom); nb = N'($urandom); ns = 1'($urandom);
      stray = 0;
      for (int c = 1; c <= LAT; c++) begin
        @(posedge clk); #1;
        if (c == 2) begin a_in = ~na; b_in = N'($urandom); signed_mode = ~ns; end
        if (c < LAT && finish === 1'b1) stray++;
      end
      chk($sformatf("b2b%0d_finish", k), finish, 1);
      chk($sformatf("b2b%0d_out", k), out, eo);
      chk($sformatf("b2b%0d_bcd", k), bcd, eb);
      chk($sformatf("b2b%0d_neg", k), neg, en);
      chk($sformatf("b2b%0d_stray", k), stray, 0);
      if (k < 2) begin
        a_in = na; b_in = nb; signed_mode = ns;
        ca = na; cb = nb; cs = ns;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_finish_fall", k), finish, 0);
      chk($sformatf("b2b%0d_busy", k), busy, (k < 2) ? 1 : 0);
    end
    @(posedge clk); #1;

    // Reset during the second MUL cycle aborts the operation.
    do_op(5'd9, 5'd7, 1'b0, 10'd63, 16'h0063, 1'b0, "pre_rst");
    a_in = 5'd9; b_in = 5'd7; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_out", out, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_neg", neg, 0);
    chk("abort_busy", busy, 0);
    chk("abort_finish", finish, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fin_cnt = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(posedge clk); #1;
      if (finish === 1'b1) fin_cnt++;
    end
    chk("abort_no_finish", fin_cnt, 0);
    do_op(5'd0, 5'd17, 1'b0, 10'd0, 16'h0000, 1'b0, "post_rst");

    // Start pulsed during CONV is ignored.
    a_in = 5'd22; b_in = 5'd19; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fin_cnt = 0; hold_out = '0; eb = '0;
    for (int c = 1; c <= 2 * (LAT + 1) + 4; c++) begin
      @(posedge clk); #1;
      if (c == N + 3) begin start = 1'b1; a_in = 5'd3; b_in = 5'd3; end
      else start = 1'b0;
      if (finish === 1'b1) begin fin_cnt++; hold_out = out; eb = bcd; end
    end
    chk("conv_start_finish_count", fin_cnt, 1);
    chk("conv_start_out", hold_out, 10'd418);
    chk("conv_start_bcd", eb, 16'h0418);
    chk("conv_start_hold", out, 10'd418);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
